// File: rtl/cpu_pkg.sv
// Shared fetch-path types: PC/instruction widths and the {instr, pc} entry
// carried from the fetch stage to decode.
package cpu_pkg;
    localparam int ADDR_W  = 6;
    localparam int INSTR_W = 16;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] instr_t;

    typedef struct packed {
        instr_t instr;
        addr_t  pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of fetch entries with synchronous flush. The head is read
// combinationally from the array so decode sees it in the cycle it becomes valid.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    fetch_entry_t     entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign pop_ok = pop & ~empty;
    assign head   = entries[rd_ptr];

    // Storage is reset too, so the head reads as zero while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: reads the instruction memory at the PC, queues {instr, pc}
// for decode and holds the PC whenever no buffer credit is left.
module instr_fetch_buffer
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_addr,
    output logic               pc_hold,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               flush,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Handshake: a transfer completes on every rising edge where
    // instr_valid & instr_ready; instr_valid never depends on instr_ready.

    logic [INSTR_W-1:0] mem [1 << ADDR_W];
    logic [INSTR_W-1:0] rdata_q;
    logic [ADDR_W-1:0]  raddr_q;
    logic               inflight;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    fetch_entry_t       push_entry;
    fetch_entry_t       head;
    logic               issue;
    logic               push;
    logic [CNT_W:0]     occ;
    logic               credit_full;

    // A pop in the same cycle does not return a credit; the hold is conservative.
    assign occ         = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
    assign credit_full = (occ >= (CNT_W + 1)'(DEPTH));
    assign pc_hold     = reset & (credit_full | prog_we);
    assign issue       = ~pc_hold & ~flush;
    assign push        = inflight & ~flush;

    // Write and read share one port process; the read sees pre-write data.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
        if (issue) begin
            rdata_q <= mem[pc_addr];
            raddr_q <= pc_addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
        end
    end

    assign push_entry.instr = rdata_q;
    assign push_entry.pc    = raddr_q;

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_entry),
        .pop      (instr_ready),
        .flush    (flush),
        .head     (head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign instr_valid = ~fifo_empty;
    assign instr_out   = head.instr;
    assign instr_pc    = head.pc;

    no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && fifo_full))
        else $error("fetch fifo overflow");
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: a reference model of credits and memory feeds
// an expected queue that is compared against every handshake at the FIFO head.
module tb_instr_fetch_buffer;
    localparam int ENT_W = 22;

    logic        clk;
    logic        reset;
    logic [5:0]  pc_addr;
    logic        pc_hold;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [15:0] prog_data;
    logic        flush;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_out;
    logic [5:0]  instr_pc;

    instr_fetch_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .pc_addr    (pc_addr),
        .pc_hold    (pc_hold),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .flush      (flush),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_out  (instr_out),
        .instr_pc   (instr_pc)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state and reference model
    logic [ENT_W-1:0] exp_q[$];
    logic [15:0]      model_mem [64];
    logic             model_inflight;
    logic [ENT_W-1:0] model_pending;
    int               checks;
    int               failures;

    logic             obs_valid, obs_hold;
    logic [ENT_W-1:0] obs_entry;
    logic             exp_valid, exp_hold, popped, issued;
    logic [ENT_W-1:0] exp_entry;

    // Driver: called at a falling edge, applies one cycle of inputs, samples
    // the outputs before the rising edge and advances the model across it.
    task automatic drive_cycle(input logic [5:0] pc, input logic rdy, input logic fl,
                               input logic we, input logic [5:0] wa, input logic [15:0] wd);
        pc_addr     = pc;
        instr_ready = rdy;
        flush       = fl;
        prog_we     = we;
        prog_addr   = wa;
        prog_data   = wd;
        #1;
        obs_valid = instr_valid;
        obs_hold  = pc_hold;
        obs_entry = {instr_out, instr_pc};
        exp_hold  = ((exp_q.size() + int'(model_inflight)) >= 4) || we;
        exp_valid = (exp_q.size() != 0);
        exp_entry = exp_valid ? exp_q[0] : '0;
        popped    = exp_valid && rdy;
        issued    = !exp_hold && !fl;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (popped) void'(exp_q.pop_front());
            if (model_inflight) exp_q.push_back(model_pending);
        end
        model_inflight = issued;
        if (issued) model_pending = {model_mem[pc], pc};
        if (we) model_mem[wa] = wd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pc_addr = '0; instr_ready = 1'b0; flush = 1'b0;
        prog_we = 1'b1; prog_addr = 6'd9; prog_data = 16'h1234;
        exp_q.delete();
        model_inflight = 1'b0;
        model_pending  = '0;
        #12;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (pc_hold !== 1'b0) begin failures++; $display("FAIL reset_hold: got %b want 0", pc_hold); end
        checks++; if (instr_out !== 16'h0) begin failures++; $display("FAIL reset_instr: got %h want 0000", instr_out); end
        checks++; if (instr_pc !== 6'd0) begin failures++; $display("FAIL reset_pc: got %0d want 0", instr_pc); end
        prog_we = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_program();
        for (int i = 0; i < 64; i++) begin
            drive_cycle(6'd0, 1'b1, 1'b0, 1'b1, 6'(i), 16'hA000 + 16'(i));
            checks++; if (obs_hold !== 1'b1) begin failures++; $display("FAIL prog_hold[%0d]: got %b want 1", i, obs_hold); end
            checks++; if (obs_valid !== 1'b0) begin failures++; $display("FAIL prog_valid[%0d]: got %b want 0", i, obs_valid); end
        end
    endtask

    task automatic test_stream();
        logic [5:0] pc = 6'd0;
        int first_valid = -1;
        for (int k = 0; k < 25; k++) begin
            drive_cycle(pc, 1'b1, 1'b0, 1'b0, 6'd0, 16'h0);
            if (issued) pc++;
            if (obs_valid && first_valid < 0) first_valid = k;
            checks++; if (obs_hold !== exp_hold) begin failures++; $display("FAIL stream_hold[%0d]: got %b want %b", k, obs_hold, exp_hold); end
            checks++; if (obs_valid !== exp_valid) begin failures++; $display("FAIL stream_valid[%0d]: got %b want %b", k, obs_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (obs_entry !== exp_entry) begin failures++; $display("FAIL stream_entry[%0d]: got %h/%0d want %h/%0d", k, obs_entry[21:6], obs_entry[5:0], exp_entry[21:6], exp_entry[5:0]); end
            end
        end
        checks++; if (first_valid != 2) begin failures++; $display("FAIL stream_latency: got %0d want 2", first_valid); end
        drive_cycle(6'd0, 1'b1, 1'b1, 1'b0, 6'd0, 16'h0);
    endtask

    task automatic test_wrap();
        logic [5:0] pcs [7] = '{6'd62, 6'd63, 6'd0, 6'd1, 6'd2, 6'd3, 6'd4};
        logic [5:0] want_pc [4] = '{6'd62, 6'd63, 6'd0, 6'd1};
        logic [15:0] want_in [4] = '{16'hA03E, 16'hA03F, 16'hA000, 16'hA001};
        logic [ENT_W-1:0] got [$];
        for (int k = 0; k < 7; k++) begin
            drive_cycle(pcs[k], 1'b1, 1'b0, 1'b0, 6'd0, 16'h0);
            if (obs_valid) got.push_back(obs_entry);
            if (exp_valid) begin
                checks++; if (obs_entry !== exp_entry) begin failures++; $display("FAIL wrap_entry[%0d]: got %h/%0d want %h/%0d", k, obs_entry[21:6], obs_entry[5:0], exp_entry[21:6], exp_entry[5:0]); end
            end
        end
        checks++; if (got.size() < 4) begin failures++; $display("FAIL wrap_count: got %0d want >=4", got.size()); end
        for (int j = 0; j < 4 && j < got.size(); j++) begin
            checks++; if (got[j] !== {want_in[j], want_pc[j]}) begin failures++; $display("FAIL wrap_order[%0d]: got %h/%0d want %h/%0d", j, got[j][21:6], got[j][5:0], want_in[j], want_pc[j]); end
        end
        drive_cycle(6'd0, 1'b1, 1'b1, 1'b0, 6'd0, 16'h0);
    endtask

    task automatic test_backpressure();
        logic [5:0] pc = 6'd8;
        int first_pop = -1;
        logic hold_at_pop = 1'b0, hold_after_pop = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive_cycle(pc, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0);
            if (issued) pc++;
            checks++; if (obs_hold !== exp_hold) begin failures++; $display("FAIL bp_hold[%0d]: got %b want %b", k, obs_hold, exp_hold); end
            checks++; if (obs_valid !== exp_valid) begin failures++; $display("FAIL bp_valid[%0d]: got %b want %b", k, obs_valid, exp_valid); end
        end
        checks++; if (pc !== 6'd12) begin failures++; $display("FAIL bp_filled: got %0d issues want 4", pc - 6'd8); end
        for (int k = 0; k < 8; k++) begin
            drive_cycle(pc, 1'b1, 1'b0, 1'b0, 6'd0, 16'h0);
            if (issued) pc++;
            if (k == 0) hold_at_pop = obs_hold;
            if (k == 1) hold_after_pop = obs_hold;
            if (obs_valid && first_pop < 0) first_pop = k;
            if (exp_valid) begin
                checks++; if (obs_entry !== exp_entry) begin failures++; $display("FAIL bp_drain[%0d]: got %h/%0d want %h/%0d", k, obs_entry[21:6], obs_entry[5:0], exp_entry[21:6], exp_entry[5:0]); end
            end
        end
        checks++; if (first_pop != 0) begin failures++; $display("FAIL bp_first_pop: got %0d want 0", first_pop); end
        checks++; if (hold_at_pop !== 1'b1) begin failures++; $display("FAIL bp_hold_at_pop: got %b want 1", hold_at_pop); end
        checks++; if (hold_after_pop !== 1'b0) begin failures++; $display("FAIL bp_hold_release: got %b want 0", hold_after_pop); end
        drive_cycle(6'd0, 1'b1, 1'b1, 1'b0, 6'd0, 16'h0);
    endtask

    task automatic test_flush();
        logic [5:0] pc = 6'd16;
        logic [5:0] first_pc = 6'd0;
        logic seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_cycle(pc, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0);
            if (issued) pc++;
        end
        drive_cycle(6'd50, 1'b0, 1'b1, 1'b0, 6'd0, 16'h0);
        checks++; if (obs_valid !== 1'b1) begin failures++; $display("FAIL flush_pre_valid: got %b want 1", obs_valid); end
        checks++; if (obs_hold !== 1'b1) begin failures++; $display("FAIL flush_pre_hold: got %b want 1", obs_hold); end
        pc = 6'd20;
        for (int k = 0; k < 5; k++) begin
            drive_cycle(pc, 1'b1, 1'b0, 1'b0, 6'd0, 16'h0);
            if (issued) pc++;
            if (k == 0) begin
                checks++; if (obs_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b want 0", obs_valid); end
                checks++; if (obs_hold !== 1'b0) begin failures++; $display("FAIL flush_hold: got %b want 0", obs_hold); end
            end
            if (obs_valid && !seen) begin seen = 1'b1; first_pc = obs_entry[5:0]; end
            if (exp_valid) begin
                checks++; if (obs_entry !== exp_entry) begin failures++; $display("FAIL flush_entry[%0d]: got %h/%0d want %h/%0d", k, obs_entry[21:6], obs_entry[5:0], exp_entry[21:6], exp_entry[5:0]); end
            end
        end
        checks++; if (!seen || first_pc !== 6'd20) begin failures++; $display("FAIL flush_restart: got %0d want 20", first_pc); end
        drive_cycle(6'd0, 1'b1, 1'b1, 1'b0, 6'd0, 16'h0);
    endtask

    task automatic test_prog_fetch();
        logic [5:0] pc = 6'd0;
        logic got_beef = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 3) begin
                drive_cycle(pc, 1'b1, 1'b0, 1'b1, 6'd5, 16'hBEEF);
                checks++; if (obs_hold !== 1'b1) begin failures++; $display("FAIL pw_hold: got %b want 1", obs_hold); end
            end else begin
                drive_cycle(pc, 1'b1, 1'b0, 1'b0, 6'd0, 16'h0);
            end
            if (issued) pc++;
            if (obs_valid && obs_entry[5:0] == 6'd5) got_beef = (obs_entry[21:6] === 16'hBEEF);
            if (exp_valid) begin
                checks++; if (obs_entry !== exp_entry) begin failures++; $display("FAIL pw_entry[%0d]: got %h/%0d want %h/%0d", k, obs_entry[21:6], obs_entry[5:0], exp_entry[21:6], exp_entry[5:0]); end
            end
        end
        checks++; if (!got_beef) begin failures++; $display("FAIL pw_beef: got no BEEF at pc 5 want BEEF"); end
        drive_cycle(6'd0, 1'b1, 1'b1, 1'b0, 6'd0, 16'h0);
    endtask

    task automatic test_async_reset();
        logic [5:0] pc = 6'd30;
        logic [5:0] first_pc = 6'd0;
        logic seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_cycle(pc, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0);
            if (issued) pc++;
        end
        prog_we = 1'b1; prog_addr = 6'd63; prog_data = 16'hA03F;
        #1;
        checks++; if (pc_hold !== 1'b1) begin failures++; $display("FAIL ar_pre_hold: got %b want 1", pc_hold); end
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL ar_pre_valid: got %b want 1", instr_valid); end
        #1 reset = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL ar_valid: got %b want 0", instr_valid); end
        checks++; if (pc_hold !== 1'b0) begin failures++; $display("FAIL ar_hold: got %b want 0", pc_hold); end
        checks++; if (instr_out !== 16'h0) begin failures++; $display("FAIL ar_instr: got %h want 0000", instr_out); end
        checks++; if (instr_pc !== 6'd0) begin failures++; $display("FAIL ar_pc: got %0d want 0", instr_pc); end
        prog_we = 1'b0;
        exp_q.delete();
        model_inflight = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        pc = 6'd40;
        for (int k = 0; k < 6; k++) begin
            drive_cycle(pc, 1'b1, 1'b0, 1'b0, 6'd0, 16'h0);
            if (issued) pc++;
            if (obs_valid && !seen) begin seen = 1'b1; first_pc = obs_entry[5:0]; end
            if (exp_valid) begin
                checks++; if (obs_entry !== exp_entry) begin failures++; $display("FAIL ar_entry[%0d]: got %h/%0d want %h/%0d", k, obs_entry[21:6], obs_entry[5:0], exp_entry[21:6], exp_entry[5:0]); end
            end
        end
        checks++; if (!seen || first_pc !== 6'd40) begin failures++; $display("FAIL ar_restart: got %0d want 40", first_pc); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_program();
        test_stream();
        test_wrap();
        test_backpressure();
        test_flush();
        test_prog_fetch();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_fetch_buffer.md
Name: instr_fetch_buffer

Overview:
- Fetch stage directly downstream of the 6-bit program counter.
- Samples the PC address each cycle and reads a 64-entry synchronous instruction memory that software loads through a program port.
- Queues each fetched {instruction, pc} pair in a small FIFO and hands it to decode over a valid/ready handshake.
- Drives pc_hold back to the PC when no buffer space is left, so no fetched instruction is ever dropped.

Parameters:
- ADDR_W, 6, width of PC / memory address; memory depth is 2**ADDR_W.
- INSTR_W, 16, instruction width.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_addr  in  ADDR_W  current PC value.
- pc_hold  out  1  1 = PC must not advance this cycle.
- prog_we  in  1  program-load write enable.
- prog_addr  in  ADDR_W  program-load address.
- prog_data  in  INSTR_W  program-load data.
- flush  in  1  synchronous discard of all queued and in-flight fetches.
- instr_valid  out  1  FIFO head is valid.
- instr_ready  in  1  decode accepts the head.
- instr_out  out  INSTR_W  head instruction.
- instr_pc  out  ADDR_W  address the head instruction was fetched from.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While reset=0: FIFO empty, inflight=0, instr_valid=0, instr_out=0, instr_pc=0, pc_hold=0. Memory contents are not reset.
- Reset mid-operation: all queued and in-flight fetches are lost. The first fetch after release uses pc_addr at the first rising edge with reset=1.
- Occupancy: occ = fifo_count + inflight, built from registered values only.
- Hold: pc_hold = (occ >= DEPTH) | prog_we. This is conservative: a pop in the same cycle does not release the hold.
- Issue: issue = ~pc_hold & ~flush. At a rising edge with issue=1: rdata_q <= mem[pc_addr], raddr_q <= pc_addr, inflight <= 1. Otherwise inflight <= 0.
- Push: when inflight=1 and flush=0, {rdata_q, raddr_q} is pushed at the next edge.
- Latency: pc_addr sampled at edge N appears at the FIFO head (instr_valid=1) right after edge N+1, if the FIFO was empty.
- Pop: a handshake completes when instr_valid & instr_ready. The head is combinational from the FIFO array and pointer.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Overflow: a push into a full FIFO cannot occur, because credits cover it. This is an assertion, not handled logic.
- Pop when empty: ignored. With instr_valid=0, instr_out/instr_pc hold their last value; nothing is specified about them.
- Flush: at the edge, count <= 0, pointers <= 0, inflight <= 0, and the current cycle's issue is suppressed.
  - Flush has priority over a simultaneous push or pop; the popped entry is still considered consumed.
- Program port: mem[prog_addr] <= prog_data on the edge when prog_we=1.
  - No fetch issues while prog_we=1.
  - Read-first: a read and a write to the same address at the same edge returns the old data. This case only arises through the array primitive, since issue is blocked while prog_we=1.
- Wrap-around: addresses are taken verbatim; 63 followed by 0 needs no special case. FIFO pointers wrap modulo DEPTH.
- Ordering: instructions leave the FIFO in the order they were issued.

Decomposition:
- Package cpu_pkg holds:
  - constants ADDR_W=6 and INSTR_W=16;
  - typedef addr_t, logic [ADDR_W-1:0];
  - typedef instr_t, logic [INSTR_W-1:0];
  - packed struct fetch_entry_t {instr_t instr; addr_t pc}.
- One sub-module, fetch_fifo: generic DEPTH-entry FIFO of fetch_entry_t, with push, pop, flush, count, full and empty.
- Memory array, credit logic and issue register stay in the top level.

Test Plan:
- Program mem[i]=16'hA000+i for i=0..63, then free-run pc_addr 0,1,2... with instr_ready=1.
  - Required: first instr_valid 2 edges after sampling pc 0; instr_out/instr_pc = A000/0, A001/1, ... with no gaps.
- pc_addr 62,63,0,1.
  - Required: outputs A03E/62, A03F/63, A000/0, A001/1 in order.
- instr_ready=0 for 10 cycles from empty.
  - Required: exactly 4 entries fill; pc_hold=1 once occ=4.
  - Then instr_ready=1: entries drain in order, pc_hold drops the cycle after the first pop, no duplicates or skips.
- FIFO holding 3 entries, inflight=1, then flush=1 for one cycle.
  - Required: next cycle instr_valid=0, occ=0.
  - First output afterwards is the pc_addr sampled on the first edge after flush.
- prog_we=1 writing mem[5]=16'hBEEF while fetching.
  - Required: pc_hold=1 and no issue during the write.
  - A later fetch of pc 5 returns BEEF.
- Drive reset=0 asynchronously mid-stream with 2 entries queued.
  - Required: instr_valid, pc_hold, instr_out and instr_pc go to 0 immediately, without a clock edge.
  - After release, fetching restarts cleanly.
